// File: rtl/fifo_lifo_buffer.sv
// Mode-selectable FIFO/LIFO storage buffer with occupancy count
// and one-cycle overflow/underflow pulses.
module fifo_lifo_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] d,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_mode;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic             w_mode;
    logic             w_switch;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_rd_base;
    logic [PTR_W-1:0] w_wr_base;
    logic [PTR_W-1:0] w_top;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W-1:0] w_raddr;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Mode is only honoured while empty, so ordering never changes under data.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == CNT_W'(DEPTH));
        w_mode    = w_empty ? mode : r_mode;
        w_switch  = w_empty && (mode != r_mode);
        w_rd_base = w_switch ? '0 : r_rd_ptr;
        w_wr_base = w_switch ? '0 : r_wr_ptr;
        w_push_ok = push && (!w_full || pop);
        w_pop_ok  = pop && !w_empty;
        w_top     = PTR_W'(r_count - CNT_W'(1));
        w_waddr   = w_wr_base;
        w_raddr   = w_rd_base;
        if (w_mode) begin
            // A simultaneous push in LIFO replaces the entry being popped.
            w_waddr = w_pop_ok ? w_top : PTR_W'(r_count);
            w_raddr = w_top;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[w_waddr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_mode    <= 1'b0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_mode    <= w_mode;
            r_q_valid <= w_pop_ok;
            r_ovf     <= push && w_full && !pop;
            r_udf     <= pop && w_empty;
            if (w_pop_ok) begin
                r_q <= r_mem[w_raddr];
            end
            r_rd_ptr <= (!w_mode && w_pop_ok) ? f_inc(w_rd_base) : w_rd_base;
            r_wr_ptr <= (!w_mode && w_push_ok) ? f_inc(w_wr_base) : w_wr_base;
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign count     = r_count;
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_fifo_lifo_buffer.sv
// Bench for fifo_lifo_buffer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fifo_lifo_buffer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [W-1:0]  d;
    logic          push;
    logic          pop;
    logic [W-1:0]  q;
    logic          q_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    bit           mm;
    logic [W-1:0] eq;
    bit           eqv;
    bit           eovf;
    bit           eudf;

    fifo_lifo_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .mode(mode), .d(d),
        .push(push), .pop(pop), .q(q), .q_valid(q_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit pu, input bit po, input logic [W-1:0] dd, input bit md);
        bit was_empty;
        bit was_full;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == D);
        if (was_empty) mm = md;
        eqv = 0; eovf = 0; eudf = 0;
        if (po && was_empty) eudf = 1;
        if (po && !was_empty) begin
            eqv = 1;
            eq  = mm ? mq.pop_back() : mq.pop_front();
        end
        if (pu) begin
            if (was_full && !po) eovf = 1;
            else mq.push_back(dd);
        end
    endtask

    task automatic step(input bit pu, input bit po, input logic [W-1:0] dd, input bit md);
        @(negedge clk);
        reset = 0; push = pu; pop = po; d = dd; mode = md;
        @(posedge clk);
        model_step(pu, po, dd, md);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; push = 0; pop = 0;
        @(posedge clk);
        mq.delete(); mm = 0; eq = '0; eqv = 0; eovf = 0; eudf = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b want 0", q_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_fifo_basic();
        logic [W-1:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, 0, v[i], 0);
        checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fifo_full: got full=%b cnt=%0d want 1/4", full, count); end
        step(1, 0, 8'h55, 0);
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fifo_ovf: got ovf=%b cnt=%0d want 1/4", overflow, count); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            checks++; if (q !== v[i] || q_valid !== 1'b1) begin errors++; $display("FAIL fifo_pop%0d: got %h/%b want %h/1", i, q, q_valid, v[i]); end
            if (i == 0) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fifo_ovf_pulse: got %b want 0", overflow); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fifo_empty: got %b want 1", empty); end
    endtask

    task automatic test_lifo();
        logic [W-1:0] v[3] = '{8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 3; i++) step(1, 0, v[i], 1);
        for (int i = 2; i >= 0; i--) begin
            step(0, 1, 8'h00, 1);
            checks++; if (q !== v[i] || q_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop%0d: got %h/%b want %h/1", i, q, q_valid, v[i]); end
        end
        step(0, 1, 8'h00, 1);
        checks++; if (underflow !== 1'b1 || q !== 8'hA1 || q_valid !== 1'b0) begin
            errors++; $display("FAIL lifo_udf: got udf=%b q=%h qv=%b want 1/a1/0", underflow, q, q_valid);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_v[4] = '{8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 1; i <= 3; i++) step(1, 0, 8'(i), 0);
        for (int i = 1; i <= 2; i++) begin
            step(0, 1, 8'h00, 0);
            checks++; if (q !== 8'(i)) begin errors++; $display("FAIL wrap_pre%0d: got %h want %h", i, q, 8'(i)); end
        end
        for (int i = 4; i <= 6; i++) step(1, 0, 8'(i), 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            checks++; if (q !== exp_v[i]) begin errors++; $display("FAIL wrap_pop%0d: got %h want %h", i, q, exp_v[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] drain[4] = '{8'd2, 8'd3, 8'd4, 8'd5};
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
        step(1, 1, 8'd5, 0);
        checks++; if (q !== 8'd1 || count !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_fifo: got q=%h cnt=%0d ovf=%b want 01/4/0", q, count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            checks++; if (q !== drain[i]) begin errors++; $display("FAIL b2b_drain%0d: got %h want %h", i, q, drain[i]); end
        end
        step(1, 0, 8'd7, 1);
        step(1, 0, 8'd8, 1);
        step(1, 1, 8'd9, 1);
        checks++; if (q !== 8'd8 || count !== 3'd2) begin errors++; $display("FAIL b2b_lifo: got q=%h cnt=%0d want 08/2", q, count); end
        step(0, 1, 8'h00, 1);
        checks++; if (q !== 8'd9) begin errors++; $display("FAIL b2b_lifo_p1: got %h want 09", q); end
        step(0, 1, 8'h00, 1);
        checks++; if (q !== 8'd7) begin errors++; $display("FAIL b2b_lifo_p2: got %h want 07", q); end
        step(1, 1, 8'h3C, 1);
        checks++; if (underflow !== 1'b1 || count !== 3'd1 || q_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: got udf=%b cnt=%0d qv=%b want 1/1/0", underflow, count, q_valid);
        end
        step(0, 1, 8'h00, 1);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL b2b_empty_pop: got %h want 3c", q); end
    endtask

    task automatic test_mode_lock_reset();
        step(1, 0, 8'h10, 0);
        step(1, 0, 8'h20, 0);
        step(0, 1, 8'h00, 1);
        checks++; if (q !== 8'h10) begin errors++; $display("FAIL lock_order: got %h want 10", q); end
        step(1, 0, 8'h40, 1);
        step(1, 0, 8'h50, 1);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL lock_count: got %0d want 3", count); end
        do_reset();
        checks++; if (count !== 3'd0 || empty !== 1'b1 || q !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got cnt=%0d empty=%b q=%h want 0/1/00", count, empty, q);
        end
        step(1, 0, 8'hB1, 1);
        step(1, 0, 8'hB2, 1);
        step(0, 1, 8'h00, 1);
        checks++; if (q !== 8'hB2) begin errors++; $display("FAIL post_reset_lifo: got %h want b2", q); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 1'($urandom_range(0, 3) == 0 ? 1 : 0) ^ (c >= 200));
            end
            checks++;
            if (q !== eq || q_valid !== eqv || overflow !== eovf || underflow !== eudf) begin
                errors++;
                $display("FAIL rnd_out cyc %0d: got q=%h qv=%b ovf=%b udf=%b want %h/%b/%b/%b",
                         c, q, q_valid, overflow, underflow, eq, eqv, eovf, eudf);
            end
            checks++;
            if (count !== CW'(mq.size()) || full !== (mq.size() == D) || empty !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL rnd_status cyc %0d: got cnt=%0d full=%b empty=%b want cnt=%0d",
                         c, count, full, empty, mq.size());
            end
        end
    endtask

    initial begin
        reset = 1; mode = 0; d = '0; push = 0; pop = 0;
        mm = 0; eq = '0; eqv = 0; eovf = 0; eudf = 0;
        test_reset();
        test_fifo_basic();
        test_lifo();
        test_wrap();
        test_back_to_back();
        test_mode_lock_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_lifo_buffer.md
# fifo_lifo_buffer

Parametrised, mode-selectable storage buffer that generalises the team's single-mode stack into a FIFO/LIFO queue with full/empty status, occupancy count and error pulses. It sits between a producer and a consumer in the same clock domain. It is the common buffer primitive for the Fifo_Lifo testbench family, and the DUT that the directed and random benches target.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, power of two not required)
- CNT_W, $clog2(DEPTH+1), derived; width of count, not to be overridden
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock and a synchronous active-high reset, fixed
- mode  input  1  requested ordering: 0 = FIFO, 1 = LIFO
- d  input  WIDTH  push data
- push  input  1  write request
- pop  input  1  read request
- q  output  WIDTH  registered pop data
- q_valid  output  1  one-cycle pulse, q updated by an accepted pop
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  CNT_W  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse, push rejected
- underflow  output  1  one-cycle pulse, pop rejected

## Operation
- Internal state: storage array [0:DEPTH-1], rd_ptr, wr_ptr (FIFO), count, mode_r.
- mode_r loads mode on every edge where empty==1 before the edge. While non-empty, mode is ignored, so ordering never changes with data inside.
- FIFO (mode_r=0): push writes mem[wr_ptr], wr_ptr+1. Pop reads mem[rd_ptr] into q, rd_ptr+1. Pointers wrap DEPTH-1 → 0 for any DEPTH.
- LIFO (mode_r=1): count is the stack pointer. Push writes mem[count]. Pop reads mem[count-1].
- On an FIFO→LIFO or LIFO→FIFO switch, rd_ptr and wr_ptr reset to 0 (buffer is empty, so no data is lost).
- Acceptance rules, evaluated on state before the edge:
  - push only, not full: write, count+1.
  - push only, full: dropped, overflow=1, state unchanged.
  - pop only, not empty: read, count-1, q_valid=1.
  - pop only, empty: underflow=1, q holds, q_valid=0.
  - push+pop, empty: push accepted, pop rejected (underflow=1), count=1.
  - push+pop, non-empty, FIFO: both accepted, including when full. q=oldest, d goes to the tail, count unchanged.
  - push+pop, non-empty, LIFO: q=current top, then top entry is overwritten with d, count unchanged. No overflow when full.
- count never exceeds DEPTH and never goes below 0.

## Timing
- Reset, synchronous, has priority over push/pop on the same edge.
  - After reset: q=0, q_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0, rd_ptr=wr_ptr=0, mode_r=0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all contents. The next cycle behaves as freshly reset, and mode is sampled again.
- All outputs are registered and reflect state after the edge.
- Pop latency: pop sampled at edge N gives q/q_valid valid after edge N. q holds its value until the next accepted pop.
- Write-to-read: data pushed at edge N can be popped at edge N+1.
- full, empty and count update on the same edge as the push or pop that changes them.
- overflow and underflow are high for exactly the cycle following the offending edge.

## Test plan
- Bench config: WIDTH=8, DEPTH=4.
- Reset, then FIFO: push 0x11,0x22,0x33,0x44 → full=1, count=4; push 0x55 → overflow pulse, count stays 4; pop ×4 → q=0x11,0x22,0x33,0x44, each with a q_valid pulse; then empty=1.
- LIFO (mode=1 while empty): push 0xA1,0xA2,0xA3; pop ×3 → q=0xA3,0xA2,0xA1; a fourth pop → underflow pulse, q stays 0xA1, q_valid=0.
- Wrap-around, FIFO: push 3, pop 2, push 3 (wr_ptr wraps) → count=4; pop ×4 returns the data in push order.
- Simultaneous push+pop:
  - FIFO full [1,2,3,4] with push 5 + pop → q=1, count=4; queue then drains 2,3,4,5.
  - LIFO [7,8] with push 9 + pop → q=8, count=2; subsequent pops give 9,7.
  - Empty with push+pop → underflow pulse, count=1.
- Mode lock and reset: in FIFO holding 2 entries, drive mode=1 → ordering stays FIFO. Assert reset for one edge while count=3 → count=0, empty=1, q=0 next cycle; the new mode=1 then takes effect.
